uart_rx_framer: RTL and testbench
=================================

// Module: uart_rx_framer
// PURPOSE
//   Parametrised UART receiver, next generation of the fixed 8N1/8-parity RX inside UART.
//   Supports configurable data width, parity mode and stop-bit count at elaboration time.
//   Oversamples the line and reports parity and framing errors per frame.
//   Sits between the RX pin and the ALU interface, and is driven by the baud-rate tick generator.
// PARAMETERS
//   DATA_WIDTH   8   data bits per frame, 5..9, sent LSB first
//   PARITY_MODE  1   0 = none, 1 = even, 2 = odd
//   STOP_WIDTH   1   number of stop bits, 1 or 2
//   OVERSAMPLE   16  i_tick pulses per bit period; even, >= 4
// PORTS
//   i_clock        in   1           system clock; all logic on rising edge
//   i_reset        in   1           asynchronous, active-low reset
//   i_tick         in   1           1-cycle enable pulse at OVERSAMPLE x baud
//   i_rx           in   1           serial line, idle high; asynchronous to i_clock
//   o_rx_done      out  1           1-cycle pulse, frame complete
//   o_rx_data      out  DATA_WIDTH  last received data word
//   o_rx_parity    out  1           last received parity bit; 0 when PARITY_MODE = 0
//   o_parity_err   out  1           parity mismatch on last frame
//   o_frame_err    out  1           a stop bit sampled low on last frame
//   o_busy         out  1           1 in any state other than IDLE
// BEHAVIOUR
//   - Reset (i_reset = 0, any time, including mid-frame):
//     - state = IDLE; all outputs = 0; counters = 0; both synchroniser flops = 1.
//     - Takes effect immediately. A partial frame is discarded and no o_rx_done is issued.
//   - i_rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
//   - Counters advance only on cycles where i_tick = 1:
//     - tick_cnt is $clog2(OVERSAMPLE) bits wide.
//     - bit_cnt counts data and stop bits.
//   - FSM:
//     - IDLE: when rx_s = 0, go to START with tick_cnt = 0.
//     - START: when tick_cnt = OVERSAMPLE/2-1 (mid start bit), check rx_s.
//       - rx_s = 0: go to DATA with tick_cnt = 0, bit_cnt = 0.
//       - rx_s = 1: glitch. Return to IDLE with no pulse and outputs unchanged.
//     - DATA: when tick_cnt = OVERSAMPLE-1 (mid bit), sample rx_s.
//       - Shift the sample in at the MSB of a DATA_WIDTH shift register (shift right).
//       - Clear tick_cnt.
//       - At bit_cnt = DATA_WIDTH-1, go to PARITY if PARITY_MODE != 0, else to STOP (bit_cnt = 0).
//     - PARITY: at mid bit, latch rx_s as the parity bit, then go to STOP.
//     - STOP: at mid bit of each stop bit, OR (~rx_s) into ferr.
//       - After stop bit STOP_WIDTH, load the outputs and pulse o_rx_done.
//       - Next state is BREAK if ferr = 1 and rx_s = 0, else IDLE.
//     - BREAK: wait until rx_s = 1, then go to IDLE. Prevents a held-low line from retriggering.
//   - Output load (same clock edge that raises o_rx_done):
//     - o_rx_data = shift register.
//     - o_rx_parity = latched parity bit.
//     - o_parity_err (even mode): ^{data, par} = 1.
//     - o_parity_err (odd mode): ^{data, par} = 0.
//     - o_parity_err (none): 0.
//     - o_frame_err = ferr.
//     - All of these hold until the next o_rx_done or reset.
//   - Latency: o_rx_done goes high on the clock edge of the i_tick that samples the last stop bit.
//     - It is high for exactly 1 clock, never 2, even if i_tick stays high.
//   - Data is delivered even when an error flag is set. The consumer decides what to do with it.
// TESTING
//   - Configuration unless stated: DATA_WIDTH = 8, PARITY_MODE = 1, STOP_WIDTH = 1, OVERSAMPLE = 16.
//     - i_clock period 20 ns; i_tick every 10 clocks.
//   1. Reset: hold i_reset = 0 with i_rx toggling.
//      -> all outputs 0, o_busy = 0; no o_rx_done pulse.
//   2. Good frame: send 0xA5 with parity 0 and 1 stop bit.
//      -> one o_rx_done pulse; o_rx_data = 0xA5, o_rx_parity = 0, both error flags = 0.
//   3. Bad parity: send 0x3C with parity 1.
//      -> o_rx_done; o_rx_data = 0x3C, o_parity_err = 1, o_frame_err = 0.
//   4. Glitch: drive i_rx low for 5 ticks, then high.
//      -> no o_rx_done; o_busy returns to 0 within 8 ticks; outputs keep their prior values.
//   5. Break: hold i_rx low for 12 bit times, then send a good 0x55 frame.
//      -> exactly one pulse for the break frame with o_rx_data = 0x00, o_frame_err = 1;
//      -> then one pulse with o_rx_data = 0x55 and both error flags = 0.
//   6. Reset mid-DATA (after bit 3), then a good 0x81 frame.
//      -> o_busy = 0 immediately on reset; no pulse for the cut frame; next frame gives o_rx_data = 0x81.
//      -> Repeat tests 2 and 3 with DATA_WIDTH = 6, PARITY_MODE = 2, STOP_WIDTH = 2 and data 0x2A:
//         odd parity bit 0 gives no error; parity bit 1 gives o_parity_err = 1;
//         a low second stop bit gives o_frame_err = 1.

Source files
------------

// File: rtl/uart_rx_framer.sv
// Parametrised oversampling UART receiver with parity and framing checks.
// Reports each completed frame with a one-cycle done pulse and held outputs.
module uart_rx_framer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_WIDTH  = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_rx,
    output logic                  o_rx_done,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_parity,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                  rx_meta_q, rx_s_q;
    logic [2:0]            state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rpar_q, rpar_d;
    logic                  perr_q, perr_d;
    logic                  fe_q, fe_d;
    logic                  done_q, done_d;
    logic                  ferr_new;
    logic                  pxor;
    logic                  perr_calc;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Parity verdict over the assembled word and the latched parity bit.
    always_comb begin
        pxor = ^{shift_q, par_q};
        if (PARITY_MODE == 1) begin
            perr_calc = pxor;
        end else if (PARITY_MODE == 2) begin
            perr_calc = ~pxor;
        end else begin
            perr_calc = 1'b0;
        end
    end

    // Frame FSM: start qualification, bit sampling, stop check, break hold-off.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        rpar_d   = rpar_q;
        perr_d   = perr_q;
        fe_d     = fe_q;
        done_d   = 1'b0;
        ferr_new = ferr_q | ~rx_s_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                            ferr_d  = 1'b0;
                            par_d   = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (i_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d  = '0;
                        par_d   = rx_s_q;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_STOP: begin
                if (i_tick) begin
                    if (tick_q == BIT_LAST) begin
                        tick_d = '0;
                        ferr_d = ferr_new;
                        if (bit_q == STOP_LAST) begin
                            bit_d   = '0;
                            data_d  = shift_q;
                            rpar_d  = par_q;
                            perr_d  = perr_calc;
                            fe_d    = ferr_new;
                            done_d  = 1'b1;
                            state_d = (ferr_new && !rx_s_q) ? S_BREAK : S_IDLE;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and held frame results.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            rpar_q  <= 1'b0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            rpar_q  <= rpar_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            done_q  <= done_d;
        end
    end

    assign o_rx_done    = done_q;
    assign o_rx_data    = data_q;
    assign o_rx_parity  = rpar_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = fe_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: two configurations driven with serial frames,
// outputs compared every cycle against a frame-level model.
module tb_uart_rx_framer;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic rx1, rx2;

    logic       done1, par1, pe1, fe1, busy1;
    logic [7:0] data1;
    logic       done2, par2, pe2, fe2, busy2;
    logic [5:0] data2;

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t h1 = '0;
    exp_t h2 = '0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    uart_rx_framer #(
        .DATA_WIDTH(8), .PARITY_MODE(1), .STOP_WIDTH(1), .OVERSAMPLE(16)
    ) dut1 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx1),
        .o_rx_done(done1), .o_rx_data(data1), .o_rx_parity(par1),
        .o_parity_err(pe1), .o_frame_err(fe1), .o_busy(busy1)
    );

    uart_rx_framer #(
        .DATA_WIDTH(6), .PARITY_MODE(2), .STOP_WIDTH(2), .OVERSAMPLE(16)
    ) dut2 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx(rx2),
        .o_rx_done(done2), .o_rx_data(data2), .o_rx_parity(par2),
        .o_parity_err(pe2), .o_frame_err(fe2), .o_busy(busy2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // What a receiver must report for a frame, from the bits on the wire.
    function automatic exp_t model(input int w, input int mode, input int sw,
                                   input logic [8:0] data, input logic par,
                                   input logic [1:0] stops);
        exp_t e;
        int   ones;
        e.d  = '0;
        for (int i = 0; i < w; i++) e.d[i] = data[i];
        ones = $countones(e.d) + ((mode != 0 && par) ? 1 : 0);
        e.p  = (mode != 0) ? par : 1'b0;
        if (mode == 0)      e.pe = 1'b0;
        else if (mode == 1) e.pe = (ones % 2 == 1);
        else                e.pe = (ones % 2 == 0);
        e.fe = 1'b0;
        for (int i = 0; i < sw; i++) if (!stops[i]) e.fe = 1'b1;
        return e;
    endfunction

    function automatic logic good_par(input int w, input int mode,
                                      input logic [8:0] data);
        int ones = 0;
        for (int i = 0; i < w; i++) ones += data[i] ? 1 : 0;
        return (mode == 1) ? logic'(ones % 2) : logic'(ones % 2 == 0);
    endfunction

    initial begin
        tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            h1    = '0;
            h2    = '0;
            prev1 = 1'b0;
            prev2 = 1'b0;
            chk("reset_out1", {done1, busy1, data1, par1, pe1, fe1}, 0);
            chk("reset_out2", {done2, busy2, data2, par2, pe2, fe2}, 0);
        end else begin
            if (done1) begin
                chk("done1_single", {prev1, done1}, 2'b01);
                chk("done1_pending", q1.size(), 1);
                if (q1.size() > 0) h1 = q1.pop_front();
            end
            if (done2) begin
                chk("done2_single", {prev2, done2}, 2'b01);
                chk("done2_pending", q2.size(), 1);
                if (q2.size() > 0) h2 = q2.pop_front();
            end
            chk("out1", {data1, par1, pe1, fe1},
                {h1.d[7:0], h1.p, h1.pe, h1.fe});
            chk("out2", {data2, par2, pe2, fe2},
                {h2.d[5:0], h2.p, h2.pe, h2.fe});
            prev1 = done1;
            prev2 = done2;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n * 10) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic v, input int nt);
        if (sel == 0) rx1 = v;
        else          rx2 = v;
        wait_ticks(nt);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] data,
                              input logic par, input logic [1:0] stops);
        int w, mode, sw;
        w    = (sel == 0) ? 8 : 6;
        mode = (sel == 0) ? 1 : 2;
        sw   = (sel == 0) ? 1 : 2;
        if (sel == 0) q1.push_back(model(w, mode, sw, data, par, stops));
        else          q2.push_back(model(w, mode, sw, data, par, stops));
        drive(sel, 1'b0, 16);
        for (int i = 0; i < w; i++) drive(sel, data[i], 16);
        if (mode != 0) drive(sel, par, 16);
        for (int i = 0; i < sw; i++) drive(sel, stops[i], 16);
        drive(sel, 1'b1, 32);
    endtask

    initial begin
        logic [8:0] d;
        logic       p;
        logic [1:0] st;
        int         k;
        int         sel;

        rst = 1'b0;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (60) begin
            @(negedge clk);
            rx1 = 1'($urandom);
            rx2 = 1'($urandom);
        end
        chk("reset_busy1", busy1, 0);
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        wait_ticks(4);

        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        chk("good_data", data1, 8'hA5);
        chk("good_flags", {par1, pe1, fe1}, 3'b000);

        send_frame(0, 9'h03C, 1'b1, 2'b11);
        chk("badpar_data", data1, 8'h3C);
        chk("badpar_flags", {par1, pe1, fe1}, 3'b110);

        rx1 = 1'b0;
        wait_ticks(5);
        rx1 = 1'b1;
        k = 0;
        while (busy1 && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("glitch_busy_clear", busy1, 0);
        chk("glitch_hold", {data1, pe1}, {8'h3C, 1'b1});
        wait_ticks(16);

        q1.push_back(model(8, 1, 1, 9'h000, 1'b0, 2'b00));
        drive(0, 1'b0, 12 * 16);
        drive(0, 1'b1, 32);
        chk("break_data", {data1, fe1}, {8'h00, 1'b1});
        send_frame(0, 9'h055, 1'b0, 2'b11);
        chk("after_break", {data1, pe1, fe1}, {8'h55, 2'b00});

        drive(0, 1'b0, 16);
        drive(0, 1'b1, 16);
        for (int i = 0; i < 3; i++) drive(0, 1'b0, 16);
        drive(0, 1'b0, 8);
        #2 rst = 1'b0;
        #1 chk("reset_busy_now", busy1, 0);
        rx1 = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        wait_ticks(32);
        send_frame(0, 9'h081, 1'b0, 2'b11);
        chk("after_reset_data", {data1, pe1, fe1}, {8'h81, 2'b00});

        send_frame(1, 9'h02A, 1'b0, 2'b11);
        chk("odd_good", {data2, par2, pe2, fe2}, {6'h2A, 3'b000});
        send_frame(1, 9'h02A, 1'b1, 2'b11);
        chk("odd_bad", {data2, par2, pe2, fe2}, {6'h2A, 3'b110});
        send_frame(1, 9'h02A, 1'b0, 2'b01);
        chk("stop2_low", {data2, pe2, fe2}, {6'h2A, 2'b01});

        for (int n = 0; n < 16; n++) begin
            sel = n % 2;
            d   = 9'($urandom);
            p   = good_par(sel ? 6 : 8, sel ? 2 : 1, d);
            if ($urandom_range(0, 3) == 0) p = ~p;
            st  = 2'b11;
            if ($urandom_range(0, 3) == 0) st = 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 9)) @(negedge clk);
            send_frame(sel, d, p, st);
        end

        wait_ticks(20);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
